// File: rtl/mem_byte_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_engine_if
// Description : Bus bundle for mem_byte_engine. Carries the initiator request
//               and response signals plus the byte-wide RAM port.
//               slave  - the engine side (drives response and RAM outputs)
//               master - the initiator / RAM side
// Ports       : req_valid, req_wr, req_len[2:0], req_addr[31:0],
//               req_wdata[31:0]                      (request)
//               rsp_ready, rsp_data[31:0]            (response)
//               mem_din[7:0], mem_dout[7:0], mem_a[31:0], mem_wr,
//               io_buffer_full                       (RAM / I/O)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_byte_engine_if;
  logic        req_valid;
  logic        req_wr;
  logic [2:0]  req_len;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_ready;
  logic [31:0] rsp_data;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  req_valid, req_wr, req_len, req_addr, req_wdata, mem_din, io_buffer_full,
    output rsp_ready, rsp_data, mem_dout, mem_a, mem_wr
  );

  modport master (
    output req_valid, req_wr, req_len, req_addr, req_wdata, mem_din, io_buffer_full,
    input  rsp_ready, rsp_data, mem_dout, mem_a, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/mem_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_engine
// Description : Serialises 8/16/32-bit loads and stores onto a byte-wide
//               synchronous RAM. Loads are assembled little-endian and
//               optionally sign-extended; stores stall on a full UART buffer
//               when the address falls in the I/O window (mem_a[17:16]=11).
// Ports       : clk_in   - system clock
//               rst_in   - asynchronous active-high reset
//               rdy_in   - global enable, everything freezes while low
//               clear_in - pipeline flush (aborts loads, never stores)
//               bus      - request/response/RAM bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_engine (
  input  wire logic        clk_in,
  input  wire logic        rst_in,
  input  wire logic        rdy_in,
  input  wire logic        clear_in,
  mem_byte_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;        // READ: edges since accept; WRITE: byte being driven
  logic        wr_q, wr_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;        // load bytes gathered so far
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        rsp_ready_q, rsp_ready_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [2:0]  n;
  logic [2:0]  cnt_inc;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] len);
    logic s;
    s = len[2];
    case (len[1:0])
      2'd0:    return {{24{s & raw[7]}}, raw[7:0]};
      2'd1:    return {{16{s & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    return data[7:0];
      2'd1:    return data[15:8];
      2'd2:    return data[23:16];
      default: return data[31:24];
    endcase
  endfunction

  // A store to the I/O window must wait while the UART buffer is full.
  function automatic logic io_stall(input logic [1:0] addr_hi, input logic full);
    return (addr_hi == 2'b11) && full;
  endfunction

  assign n       = byte_count(len_q[1:0]);
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    rsp_ready_d = rsp_ready_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        rsp_ready_d = 1'b0;
        if (bus.req_valid && !clear_in) begin
          wr_d    = bus.req_wr;
          len_d   = bus.req_len;
          wdata_d = bus.req_wdata;
          cnt_d   = 3'd0;
          mem_a_d = bus.req_addr;
          if (bus.req_wr) begin
            mem_wr_d   = !io_stall(bus.req_addr[17:16], bus.io_buffer_full);
            mem_dout_d = bus.req_wdata[7:0];
            state_d    = WRITE;
          end else begin
            mem_wr_d = 1'b0;
            state_d  = READ;
          end
        end
      end

      READ: begin
        if (clear_in) begin
          state_d     = IDLE;
          mem_a_d     = 32'd0;
          rsp_ready_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // Keep issuing addresses until the last byte address is out.
          if (cnt_inc < n) begin
            mem_a_d = mem_a_q + 32'd1;
          end
          // RAM latency is one cycle, so byte i arrives when cnt_q = i+1.
          for (int i = 0; i < 4; i++) begin
            if (int'(cnt_q) == i + 1) begin
              asm_d[8*i +: 8] = bus.mem_din;
            end
          end
          if (cnt_q == n) begin
            rsp_data_d  = extend(asm_d, len_q);
            rsp_ready_d = 1'b1;
            state_d     = DONE;
          end
        end
      end

      WRITE: begin
        if (mem_wr_q) begin
          // The byte on the bus this cycle has been written.
          if (cnt_inc == n) begin
            mem_wr_d    = 1'b0;
            mem_a_d     = 32'd0;
            rsp_ready_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = pick_byte(wdata_q, cnt_inc[1:0]);
            mem_wr_d   = !io_stall(mem_a_d[17:16], bus.io_buffer_full);
          end
        end else begin
          // Stalled: hold the same byte until the buffer drains.
          mem_wr_d = !io_stall(mem_a_q[17:16], bus.io_buffer_full);
        end
      end

      DONE: begin
        state_d     = IDLE;
        rsp_ready_d = 1'b0;
        if (clear_in && !wr_q) begin
          mem_a_d = 32'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      wr_q        <= 1'b0;
      len_q       <= 3'd0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_ready = rsp_ready_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_engine
// Description : Directed self-checking bench for mem_byte_engine. A small
//               byte ROM (read-only, one-cycle latency, gated by rdy_in)
//               answers loads; stores are checked directly on the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_engine;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clear;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:255];

  mem_byte_engine_if bus ();

  mem_byte_engine dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .clear_in (clear),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM, one cycle read latency, shares the global enable.
  always @(posedge clk) begin
    if (rdy) bus.mem_din <= ram[bus.mem_a[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic [2:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_len   = len;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  // Issue a load and measure negedges from the issue point to rsp_ready.
  task automatic run_load(input string tag, input logic [2:0] len, input logic [31:0] addr,
                          input logic [31:0] exp, input int exp_lat);
    int lat;
    set_req(1'b0, len, addr, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, bus.rsp_data, exp);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, bus.rsp_ready}, 32'd0);
  endtask

  // Word store at addr; optionally holds clear_in high for two edges mid-store.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic use_clear, input logic [31:0] exp_rsp_data);
    logic [31:0] wd;
    wd = wdata;
    set_req(1'b1, 3'b010, addr, wdata);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      check({tag, "_wr"},   {31'd0, bus.mem_wr}, 32'd1);
      check({tag, "_addr"}, bus.mem_a, addr + i);
      check({tag, "_dout"}, {24'd0, bus.mem_dout}, {24'd0, wd[8*i +: 8]});
      if (use_clear) clear = (i < 2);
    end
    clear = 1'b0;
    @(negedge clk);
    check({tag, "_rsp"},    {31'd0, bus.rsp_ready}, 32'd1);
    check({tag, "_wr_end"}, {31'd0, bus.mem_wr}, 32'd0);
    check({tag, "_a_end"},  bus.mem_a, 32'd0);
    check({tag, "_rdata"},  bus.rsp_data, exp_rsp_data);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, bus.rsp_ready}, 32'd0);
  endtask

  initial begin
    logic seen;
    int   lat;

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = 8'h11;
    ram[8'h01] = 8'h22;
    ram[8'h02] = 8'h33;
    ram[8'h03] = 8'h44;
    ram[8'h20] = 8'h80;
    ram[8'h40] = 8'h34;
    ram[8'h41] = 8'h92;
    ram[8'hFE] = 8'hA1;
    ram[8'hFF] = 8'hB2;

    rst   = 1'b1;
    rdy   = 1'b1;
    clear = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_wr         = 1'b0;
    bus.req_len        = 3'd0;
    bus.req_addr       = 32'd0;
    bus.req_wdata      = 32'd0;
    bus.io_buffer_full = 1'b0;

    // Reset values
    #12;
    check("rst_rsp_ready", {31'd0, bus.rsp_ready}, 32'd0);
    check("rst_rsp_data",  bus.rsp_data, 32'd0);
    check("rst_mem_a",     bus.mem_a, 32'd0);
    check("rst_mem_wr",    {31'd0, bus.mem_wr}, 32'd0);
    check("rst_mem_dout",  {24'd0, bus.mem_dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Word load at 0x100: address walk, then response 5 edges after accept
    set_req(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      check("wl_mem_a",  bus.mem_a, 32'h0000_0100 + ((i < 4) ? i : 3));
      check("wl_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("wl_early",  {31'd0, bus.rsp_ready}, 32'd0);
    end
    @(negedge clk);
    check("wl_rsp",  {31'd0, bus.rsp_ready}, 32'd1);
    check("wl_data", bus.rsp_data, 32'h4433_2211);
    @(negedge clk);
    check("wl_pulse_end", {31'd0, bus.rsp_ready}, 32'd0);

    // Byte / halfword loads with and without sign extension
    run_load("lb_sext", 3'b100, 32'h0000_0020, 32'hFFFF_FF80, 3);
    run_load("lb_zext", 3'b000, 32'h0000_0020, 32'h0000_0080, 3);
    run_load("lh_sext", 3'b101, 32'h0000_0040, 32'hFFFF_9234, 4);

    // Word load straddling the top of the address space
    run_load("wrap", 3'b010, 32'hFFFF_FFFE, 32'h2211_B2A1, 6);
    check("wrap_addr", bus.mem_a, 32'h0000_0001);

    // Word store; rsp_data keeps the last load value
    run_store("ws", 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 32'h2211_B2A1);

    // Byte store into the I/O window with the UART buffer full for 3 cycles
    bus.io_buffer_full = 1'b1;
    set_req(1'b1, 3'b000, 32'h0003_0000, 32'h5A5A_5AA5);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) bus.req_valid = 1'b0;
      check("io_stall_wr",   {31'd0, bus.mem_wr}, 32'd0);
      check("io_stall_addr", bus.mem_a, 32'h0003_0000);
    end
    bus.io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_wr",   {31'd0, bus.mem_wr}, 32'd1);
    check("io_addr", bus.mem_a, 32'h0003_0000);
    check("io_dout", {24'd0, bus.mem_dout}, 32'h0000_00A5);
    @(negedge clk);
    check("io_rsp",    {31'd0, bus.rsp_ready}, 32'd1);
    check("io_wr_end", {31'd0, bus.mem_wr}, 32'd0);
    check("io_rdata",  bus.rsp_data, 32'h2211_B2A1);
    @(negedge clk);
    check("io_pulse_end", {31'd0, bus.rsp_ready}, 32'd0);

    // clear_in during a store does not abort it
    run_store("ws_clr", 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 32'h2211_B2A1);

    // clear_in two cycles into a word load aborts it without a response
    set_req(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_mem_a", bus.mem_a, 32'd0);
    check("clr_rsp",   {31'd0, bus.rsp_ready}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_ready) seen = 1'b1;
    end
    check("clr_no_rsp", {31'd0, seen}, 32'd0);
    check("clr_rdata",  bus.rsp_data, 32'h2211_B2A1);

    // rdy_in low for two cycles mid word load delays the response by two
    set_req(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("frz_a0", bus.mem_a, 32'h0000_0101);
    rdy = 1'b0;
    @(negedge clk);
    check("frz_a1", bus.mem_a, 32'h0000_0101);
    @(negedge clk);
    check("frz_a2", bus.mem_a, 32'h0000_0101);
    check("frz_rsp", {31'd0, bus.rsp_ready}, 32'd0);
    rdy = 1'b1;
    lat = 4;
    while (bus.rsp_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("frz_lat",  lat, 8);
    check("frz_data", bus.rsp_data, 32'h4433_2211);
    @(negedge clk);

    // Asynchronous reset in the middle of a store
    set_req(1'b1, 3'b010, 32'h0000_0200, 32'h1234_5678);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rs_wr_before", {31'd0, bus.mem_wr}, 32'd1);
    @(negedge clk);
    check("rs_dout_before", {24'd0, bus.mem_dout}, 32'h0000_0056);
    #2;
    rst = 1'b1;
    #1;
    check("rs_wr",    {31'd0, bus.mem_wr}, 32'd0);
    check("rs_a",     bus.mem_a, 32'd0);
    check("rs_rdata", bus.rsp_data, 32'd0);
    check("rs_rsp",   {31'd0, bus.rsp_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_ready || bus.mem_wr) seen = 1'b1;
    end
    check("rs_quiet", {31'd0, seen}, 32'd0);

    // First request after reset is served normally
    run_load("post_rst", 3'b000, 32'h0000_0020, 32'h0000_0080, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
